// File: rtl/uio_arb_pkg.sv
// Shared types, constants and the round-robin search used by the uio pad arbiter.
package uio_arb_pkg;

    localparam int unsigned UIO_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        OWN
    } arb_state_t;

    // First set bit of req at or above ptr, wrapping at n-1; result is one-hot (or zero).
    function automatic logic [7:0] rr_winner(
        input logic [7:0]  req,
        input logic [2:0]  ptr,
        input int unsigned n
    );
        logic [7:0]  win;
        logic        found;
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < n) begin
                idx = 32'(ptr) + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx[2:0]]) begin
                    win[idx[2:0]] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/uio_port_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot winner and valid flag from req and pointer.
module rr_pick
    import uio_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic               valid
);

    logic [7:0] req_ext;
    logic [7:0] win_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        win_ext                = rr_winner(req_ext, 3'(ptr), NUM_REQ);
        win                    = win_ext[NUM_REQ-1:0];
        valid                  = |win_ext;
    end

endmodule

// File: rtl/uio_port_arbiter.sv
// Round-robin owner of the shared uio pad group with an output-disabled turnaround
// between every change of owner or direction.
module uio_port_arbiter
    import uio_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       dir,
    input  logic [NUM_REQ*UIO_W-1:0] wdata,
    input  logic [UIO_W-1:0]         uio_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic [UIO_W-1:0]         rdata,
    output logic                     rvalid,
    output logic [UIO_W-1:0]         uio_out,
    output logic [UIO_W-1:0]         uio_oe,
    output logic                     busy
);

    localparam int unsigned OWN_W     = $clog2(NUM_REQ);
    localparam int unsigned TURN_W    = $clog2(TURN_CYCLES + 1);
    localparam int unsigned HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    arb_state_t        state, n_state;
    logic [OWN_W-1:0]  owner, n_owner;
    logic [OWN_W-1:0]  rr_ptr, n_rr_ptr;
    logic [TURN_W-1:0] turn_cnt, n_turn_cnt;
    logic [HOLD_W-1:0] hold_cnt, n_hold_cnt;
    logic              dir_lat, n_dir_lat;

    logic [OWN_W-1:0]   owner_inc;
    logic [OWN_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_win;
    logic               pick_valid;
    logic [OWN_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] owner_oh;
    logic               others_req;
    logic               hold_hit;
    logic               rel;
    logic               drive_nxt;

    always_comb begin
        owner_inc  = (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + OWN_W'(1);
        // Outside IDLE the pick is only consumed on a release, where the pointer has moved past owner.
        pick_ptr   = (state == IDLE) ? rr_ptr : owner_inc;
        owner_oh   = NUM_REQ'(1) << owner;
        others_req = |(req & ~owner_oh);
        hold_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(HOLD_LAST));
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (OWN_W)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .win   (pick_win),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_win[i]) begin
                pick_idx = OWN_W'(i);
            end
        end
    end

    always_comb begin
        n_state    = state;
        n_owner    = owner;
        n_rr_ptr   = rr_ptr;
        n_turn_cnt = turn_cnt;
        n_hold_cnt = hold_cnt;
        n_dir_lat  = dir_lat;
        rel        = 1'b0;

        if (!ena) begin
            n_state    = IDLE;
            n_turn_cnt = '0;
            n_hold_cnt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        n_state    = TURN;
                        n_owner    = pick_idx;
                        n_dir_lat  = dir[pick_idx];
                        n_turn_cnt = TURN_W'(TURN_CYCLES - 1);
                    end
                end
                TURN: begin
                    if (!req[owner]) begin
                        rel = 1'b1;
                    end else if (turn_cnt == '0) begin
                        n_state    = OWN;
                        n_hold_cnt = '0;
                    end else begin
                        n_turn_cnt = turn_cnt - TURN_W'(1);
                    end
                end
                OWN: begin
                    if (!req[owner] || (hold_hit && others_req)) begin
                        rel = 1'b1;
                    end else if (dir[owner] != dir_lat) begin
                        n_state    = TURN;
                        n_dir_lat  = dir[owner];
                        n_turn_cnt = TURN_W'(TURN_CYCLES - 1);
                        n_hold_cnt = '0;
                    end else if ((MAX_HOLD != 0) && !hold_hit) begin
                        n_hold_cnt = hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    n_state = IDLE;
                end
            endcase

            // A handover reloads TURN_CYCLES rather than TURN_CYCLES-1: the release cycle itself
            // has no idle lead-in, so one extra turn cycle keeps the gap at TURN_CYCLES+1.
            if (rel) begin
                n_rr_ptr   = owner_inc;
                n_hold_cnt = '0;
                if (pick_valid) begin
                    n_state    = TURN;
                    n_owner    = pick_idx;
                    n_dir_lat  = dir[pick_idx];
                    n_turn_cnt = TURN_W'(TURN_CYCLES);
                end else begin
                    n_state    = IDLE;
                    n_turn_cnt = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            turn_cnt <= '0;
            hold_cnt <= '0;
            dir_lat  <= 1'b0;
        end else begin
            state    <= n_state;
            owner    <= n_owner;
            rr_ptr   <= n_rr_ptr;
            turn_cnt <= n_turn_cnt;
            hold_cnt <= n_hold_cnt;
            dir_lat  <= n_dir_lat;
        end
    end

    assign drive_nxt = (n_state == OWN) && n_dir_lat;

    // Outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant   <= '0;
            uio_oe  <= '0;
            uio_out <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            grant   <= (n_state == OWN) ? (NUM_REQ'(1) << n_owner) : '0;
            uio_oe  <= drive_nxt ? '1 : '0;
            uio_out <= drive_nxt ? wdata[UIO_W*n_owner +: UIO_W] : '0;
            if ((state == OWN) && !dir_lat) begin
                rdata <= uio_in;
            end
            rvalid  <= (state == OWN) && !dir_lat && (n_state == OWN);
            busy    <= (n_state != IDLE);
        end
    end

endmodule

// File: doc/uio_port_arbiter.md
Name: uio_port_arbiter

Overview:
- Shares the 8-bit bidirectional uio pad group (uio_in / uio_out / uio_oe) of the top-level tt_um wrapper between NUM_REQ internal requesters.
- Arbitration is round-robin.
- A turnaround gap with outputs disabled separates every ownership or direction change, so the pads are never driven by two sources.
- Sits between the user datapath blocks and the top-level uio ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TURN_CYCLES, 1, bus-turnaround cycles with uio_oe=0 before each tenure (minimum 1).
- MAX_HOLD, 16, maximum OWN cycles before a forced release when others are waiting. 0 disables the limit.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  design-selected enable; synchronous, low forces IDLE.
- req  in  NUM_REQ  per-requester bus request, level-sensitive.
- dir  in  NUM_REQ  per-requester direction: 1 = drive pads, 0 = sample pads.
- wdata  in  NUM_REQ*8  per-requester drive data; requester i uses bits [8i+7:8i].
- uio_in  in  8  pad input path.
- grant  out  NUM_REQ  one-hot grant, high only in OWN.
- rdata  out  8  registered sample of uio_in for the current owner.
- rvalid  out  1  rdata is valid this cycle.
- uio_out  out  8  pad output data.
- uio_oe  out  8  pad output enable; all bits are equal (8'hFF or 8'h00).
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; owner=0; rr_ptr=0; turn_cnt=0; hold_cnt=0; dir_lat=0.
  - grant=0; uio_oe=8'h00; uio_out=8'h00; rdata=8'h00; rvalid=0; busy=0.
- All outputs are registered.
- Arbitration: the winner is the first requester with req=1 searching from rr_ptr upward, wrapping at NUM_REQ-1 back to 0.
- On any release, rr_ptr <= owner+1 (mod NUM_REQ).
- IDLE:
  - If ena and |req: owner<=winner, dir_lat<=dir[winner], turn_cnt<=TURN_CYCLES-1, go to TURN.
- TURN:
  - uio_oe=0, grant=0, rvalid=0.
  - When turn_cnt==0, go to OWN and clear hold_cnt. Otherwise decrement turn_cnt.
  - If req[owner] drops during TURN: treat as a release; re-arbitrate, or go to IDLE if no request is pending.
- OWN (in every cycle):
  - grant[owner]=1.
  - If dir_lat=1: uio_out<=wdata[owner], uio_oe<=8'hFF.
  - If dir_lat=0: uio_oe<=0 and rdata<=uio_in, with rvalid=1 the cycle after the sample. rvalid is therefore high from the 2nd OWN cycle.
  - hold_cnt increments each OWN cycle.
- Release from OWN, when req[owner]=0, or MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and any other req is high:
  - Registered outputs clear the next cycle (grant=0, uio_oe=0, rvalid=0).
  - Re-arbitrate immediately, excluding nothing; rr_ptr has already advanced past owner.
  - If a winner exists, go to TURN; otherwise go to IDLE.
- Direction change in OWN (dir[owner]!=dir_lat while req[owner]=1): go to TURN with the same owner, dir_lat<=dir[owner], rr_ptr unchanged, outputs disabled.
- Simultaneous release and direction change: release wins.
- Sole requester hitting MAX_HOLD: no forced release; hold_cnt saturates.
- ena=0 in any state: next state IDLE; grant, uio_oe and rvalid are 0 the next cycle; counters are cleared; rr_ptr is kept.
- Latency: req rises while IDLE → grant and uio_oe rise TURN_CYCLES+1 cycles later. Back-to-back handover → TURN_CYCLES+1 cycles with uio_oe=0 between tenures.
- Invariant: uio_oe=8'hFF only in OWN with dir_lat=1; never two grant bits high.

Decomposition:
- Shared package uio_arb_pkg:
  - state enum {IDLE, TURN, OWN}.
  - UIO_W=8 constant.
  - Function that computes the round-robin winner from (req, rr_ptr).
- One natural sub-module: rr_pick, a combinational round-robin selector taking req and rr_ptr and returning a one-hot winner and a valid flag. It can be unit-tested alone.

Test Plan:
- Reset mid-tenure: owner 1 driving 8'hA5 with uio_oe=FF; assert rst → uio_oe=00, grant=0 and uio_out=00 immediately; after deassert, busy=0.
- Single requester out: req=0001, dir=0001, wdata0=8'h3C, TURN_CYCLES=1 → grant=0001, uio_oe=FF and uio_out=3C two cycles after req; drop req → uio_oe=00 the next cycle.
- Round robin: req=1111 held with each owner releasing after 3 cycles → grant order 0,1,2,3,0, with 2 cycles of uio_oe=00 between each tenure.
- Hold limit: MAX_HOLD=4, req0 held, req2 rises → grant0 lasts 4 cycles, then TURN, then grant=0100. Same case with req0 alone → grant0 is held indefinitely.
- Input path: req=0010, dir=0, uio_in=8'h5A → uio_oe stays 00 and rdata=5A with rvalid=1 from the 2nd OWN cycle. Owner flips dir to 1 → 1 TURN cycle with grant=0, then uio_oe=FF.
- ena drop: ena=0 during OWN → next cycle grant=0, uio_oe=00 and busy=0. ena=1 with req pending → new tenure begins via TURN.
